// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - single virtual-channel router input buffer with RC/VA/SA sequencing
//
// Buffers incoming flits in a circular FIFO and presents the head flit's
// destination to the route computation unit. It latches the returned route,
// requests a downstream VC and then requests the switch until the tail is
// forwarded. Outgoing flits carry the allocated downstream VC.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   data_i            incoming flit {label[1:0], vc_id, payload}
//   valid_flit_i      data_i valid this cycle
//   read_i            switch allocation grant, pops the front flit
//   va_done_i         VC allocation granted this cycle
//   vc_new_i          allocated downstream VC, valid with va_done_i
//   out_port_i        route of the front flit from the route computation unit
//   x_dest_o          front flit x destination
//   y_dest_o          front flit y destination
//   data_o            front flit with its vc_id replaced by the allocated VC
//   out_port_o        latched route of the current packet (CENTER is encoding 0)
//   vc_request_o      requesting VC allocation
//   switch_request_o  requesting switch allocation
//   is_full_o         FIFO holds BUFFER_SIZE flits
//   is_empty_o        FIFO holds no flits
//   error_o           one-cycle protocol error pulse (registered)

module input_vc_buffer #(
  parameter int  BUFFER_SIZE    = 8,
  parameter int  VC_ID_SIZE     = 2,
  parameter int  FLIT_DATA_SIZE = 16,
  parameter int  DEST_ADDR_SIZE = 4,
  parameter type port_t         = logic [2:0]
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2+VC_ID_SIZE+FLIT_DATA_SIZE-1:0] data_i,
  input  logic                                 valid_flit_i,
  input  logic                                 read_i,
  input  logic                                 va_done_i,
  input  logic [VC_ID_SIZE-1:0]                vc_new_i,
  input  port_t                                out_port_i,
  output logic [DEST_ADDR_SIZE-1:0]            x_dest_o,
  output logic [DEST_ADDR_SIZE-1:0]            y_dest_o,
  output logic [2+VC_ID_SIZE+FLIT_DATA_SIZE-1:0] data_o,
  output port_t                                out_port_o,
  output logic                                 vc_request_o,
  output logic                                 switch_request_o,
  output logic                                 is_full_o,
  output logic                                 is_empty_o,
  output logic                                 error_o
);

  localparam int FLIT_W = 2 + VC_ID_SIZE + FLIT_DATA_SIZE;
  localparam int IDX_W  = $clog2(BUFFER_SIZE);
  localparam int PTR_W  = IDX_W + 1;
  localparam int MEM_W  = 2 + FLIT_DATA_SIZE;

  localparam logic [1:0] HEAD     = 2'd0;
  localparam logic [1:0] BODY     = 2'd1;
  localparam logic [1:0] TAIL     = 2'd2;
  localparam logic [1:0] HEADTAIL = 2'd3;

  localparam port_t CENTER = port_t'(0);

  typedef enum logic [1:0] {IDLE, VA, SA} state_t;

  state_t state, next_state;

  // The incoming vc_id is always overwritten on the way out, so it is not stored.
  logic [MEM_W-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [VC_ID_SIZE-1:0] vc_q;

  logic [1:0]                front_label;
  logic [FLIT_DATA_SIZE-1:0] front_payload;
  logic empty, full;
  logic front_is_head, front_is_last;
  logic discard, sa_pop, pop, push, bad_read, overflow, err_next;
  logic [VC_ID_SIZE-1:0] unused_in_vc;

  assign unused_in_vc  = data_i[FLIT_DATA_SIZE +: VC_ID_SIZE];

  assign front_label   = mem[rd_ptr[IDX_W-1:0]][MEM_W-1 -: 2];
  assign front_payload = mem[rd_ptr[IDX_W-1:0]][FLIT_DATA_SIZE-1:0];

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

  assign front_is_head = (front_label == HEAD) || (front_label == HEADTAIL);
  assign front_is_last = (front_label == TAIL) || (front_label == HEADTAIL);

  // A non-head flit at the front while idle belongs to no packet: drop it.
  assign discard  = (state == IDLE) && !empty && !front_is_head;
  assign sa_pop   = (state == SA) && read_i && !empty;
  assign pop      = discard || sa_pop;
  assign bad_read = read_i && !((state == SA) && !empty);
  // A pop in the same cycle frees the slot, so a write while full is legal then.
  assign push     = valid_flit_i && (!full || pop);
  assign overflow = valid_flit_i && full && !pop;
  assign err_next = discard || bad_read || overflow;

  assign x_dest_o = front_payload[DEST_ADDR_SIZE-1:0];
  assign y_dest_o = front_payload[2*DEST_ADDR_SIZE-1 -: DEST_ADDR_SIZE];
  assign data_o   = {front_label, vc_q, front_payload};
  assign is_empty_o = empty;
  assign is_full_o  = full;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (!empty && front_is_head) next_state = VA;
      VA:   if (va_done_i) next_state = SA;
      SA:   if (sa_pop && front_is_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    vc_request_o     = (state == VA);
    switch_request_o = (state == SA) && !empty;
  end

  // FIFO storage, pointers, latched route/VC and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      vc_q       <= '0;
      out_port_o <= CENTER;
      error_o    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[IDX_W-1:0]] <= {data_i[FLIT_W-1 -: 2], data_i[FLIT_DATA_SIZE-1:0]};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if ((state == IDLE) && !empty && front_is_head) out_port_o <= out_port_i;
      if ((state == VA) && va_done_i) vc_q <= vc_new_i;
      error_o <= err_next;
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - randomized and directed bench for input_vc_buffer against a queue model
module tb_input_vc_buffer;
  localparam int BS = 8, VCW = 2, DW = 16, DA = 4, W = 2 + VCW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [W-1:0] data_i;
  logic valid_flit_i, read_i, va_done_i;
  logic [VCW-1:0] vc_new_i;
  logic [2:0] out_port_i;
  logic [DA-1:0] x_dest_o, y_dest_o;
  logic [W-1:0] data_o;
  logic [2:0] out_port_o;
  logic vc_request_o, switch_request_o, is_full_o, is_empty_o, error_o;

  input_vc_buffer #(.BUFFER_SIZE(BS), .VC_ID_SIZE(VCW), .FLIT_DATA_SIZE(DW),
                    .DEST_ADDR_SIZE(DA), .port_t(logic [2:0])) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .read_i(read_i), .va_done_i(va_done_i), .vc_new_i(vc_new_i),
    .out_port_i(out_port_i), .x_dest_o(x_dest_o), .y_dest_o(y_dest_o),
    .data_o(data_o), .out_port_o(out_port_o), .vc_request_o(vc_request_o),
    .switch_request_o(switch_request_o), .is_full_o(is_full_o),
    .is_empty_o(is_empty_o), .error_o(error_o));

  localparam logic [2:0] P_CENTER = 3'd0, P_LEFT = 3'd1, P_RIGHT = 3'd2, P_UP = 3'd3, P_DOWN = 3'd4;
  localparam logic [1:0] L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HT = 2'd3;
  localparam int PH_IDLE = 0, PH_WAIT_VC = 1, PH_FORWARD = 2;

  int checks = 0, errors = 0;

  // Reference model: packet phase, FIFO contents, latched route and VC.
  logic [W-1:0] mq[$];
  int m_phase = PH_IDLE;
  logic [2:0] m_route = P_CENTER;
  logic [VCW-1:0] m_vc = '0;
  bit m_err = 0;
  int gen_left = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY route computation for a router at (2,2)
  function automatic logic [2:0] route(logic [W-1:0] f);
    int x, y;
    x = int'(f[DA-1:0]);
    y = int'(f[2*DA-1:DA]);
    if (x < 2) return P_LEFT;
    if (x > 2) return P_RIGHT;
    if (y > 2) return P_UP;
    if (y < 2) return P_DOWN;
    return P_CENTER;
  endfunction

  function automatic logic [W-1:0] mk_flit(logic [1:0] lbl, int x, int y);
    logic [DW-1:0] p;
    p = DW'($urandom);
    p[DA-1:0] = DA'(x);
    p[2*DA-1:DA] = DA'(y);
    return {lbl, VCW'($urandom), p};
  endfunction

  function automatic logic [1:0] lbl_of(logic [W-1:0] f);
    return f[W-1:W-2];
  endfunction

  task automatic model_step();
    bit pop, err;
    logic [W-1:0] fr;
    logic [1:0] fl;
    int nphase;
    if (!rst) begin
      mq.delete();
      m_phase = PH_IDLE; m_route = P_CENTER; m_vc = '0; m_err = 0;
      return;
    end
    pop = 0; err = 0; nphase = m_phase;
    fr = (mq.size() > 0) ? mq[0] : '0;
    fl = lbl_of(fr);
    if (m_phase == PH_IDLE && mq.size() > 0 && (fl == L_BODY || fl == L_TAIL)) begin
      pop = 1; err = 1;
    end
    if (read_i) begin
      if (m_phase == PH_FORWARD && mq.size() > 0) pop = 1;
      else err = 1;
    end
    if (m_phase == PH_IDLE && mq.size() > 0 && (fl == L_HEAD || fl == L_HT)) begin
      m_route = out_port_i; nphase = PH_WAIT_VC;
    end else if (m_phase == PH_WAIT_VC && va_done_i) begin
      m_vc = vc_new_i; nphase = PH_FORWARD;
    end else if (m_phase == PH_FORWARD && pop && (fl == L_TAIL || fl == L_HT)) begin
      nphase = PH_IDLE;
    end
    if (valid_flit_i && mq.size() == BS && !pop) err = 1;
    if (pop) void'(mq.pop_front());
    if (valid_flit_i && !err_overflow(pop)) mq.push_back(data_i);
    m_phase = nphase;
    m_err = err;
  endtask

  // Space check taken before this cycle's pop was applied (pop frees a slot).
  function automatic bit err_overflow(bit popped);
    return popped ? 1'b0 : (mq.size() == BS);
  endfunction

  task automatic check_all();
    logic [W-1:0] fr;
    check("is_empty", is_empty_o, mq.size() == 0);
    check("is_full", is_full_o, mq.size() == BS);
    check("vc_request", vc_request_o, m_phase == PH_WAIT_VC);
    check("switch_request", switch_request_o, m_phase == PH_FORWARD && mq.size() > 0);
    check("error", error_o, m_err);
    check("out_port", out_port_o, m_route);
    if (mq.size() > 0) begin
      fr = mq[0];
      check("data_o", data_o, {fr[W-1:W-2], m_vc, fr[DW-1:0]});
      check("x_dest", x_dest_o, fr[DA-1:0]);
      check("y_dest", y_dest_o, fr[2*DA-1:DA]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(bit v, logic [W-1:0] f, bit rd, bit va, logic [VCW-1:0] vn);
    valid_flit_i = v; data_i = f; read_i = rd; va_done_i = va; vc_new_i = vn;
    out_port_i = (mq.size() > 0) ? route(mq[0]) : P_CENTER;
  endtask

  task automatic idle_in();
    drive(0, '0, 0, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && !(mq.size() == 0 && m_phase == PH_IDLE); i++) begin
      drive(0, '0, m_phase == PH_FORWARD && mq.size() > 0, m_phase == PH_WAIT_VC, VCW'($urandom));
      cycle();
    end
    check("drain_done", mq.size() == 0 && m_phase == PH_IDLE, 1);
  endtask

  function automatic logic [W-1:0] gen_flit();
    int len;
    if ($urandom_range(0, 19) == 0) return mk_flit(L_BODY, $urandom_range(0, 4), $urandom_range(0, 4));
    if (gen_left == 0) begin
      len = $urandom_range(1, 5);
      gen_left = len - 1;
      return mk_flit(len == 1 ? L_HT : L_HEAD, $urandom_range(0, 4), $urandom_range(0, 4));
    end
    gen_left--;
    return mk_flit(gen_left == 0 ? L_TAIL : L_BODY, 0, 0);
  endfunction

  initial begin
    logic [W-1:0] pk[4];
    rst = 1'b0;
    idle_in();
    // Reset then idle
    cycle(); cycle();
    check("reset_data_o", data_o, 0);
    check("reset_out_port", out_port_o, P_CENTER);
    rst = 1'b1;
    cycle();

    // HEADTAIL to (0,2)
    drive(1, mk_flit(L_HT, 0, 2), 0, 0, '0); cycle();
    check("ht_x", x_dest_o, 0);
    check("ht_y", y_dest_o, 2);
    idle_in(); cycle();
    check("ht_route", out_port_o, P_LEFT);
    check("ht_vcreq", vc_request_o, 1);
    drive(0, '0, 0, 1, 2'd3); cycle();
    check("ht_swreq", switch_request_o, 1);
    check("ht_vc", data_o[DW +: VCW], 3);
    drive(0, '0, 1, 0, '0); cycle();
    check("ht_empty", is_empty_o, 1);
    check("ht_idle", vc_request_o | switch_request_o, 0);

    // 4-flit packet to (3,2)
    pk[0] = mk_flit(L_HEAD, 3, 2); pk[1] = mk_flit(L_BODY, 0, 0);
    pk[2] = mk_flit(L_BODY, 0, 0); pk[3] = mk_flit(L_TAIL, 0, 0);
    for (int i = 0; i < 4; i++) begin drive(1, pk[i], 0, 0, '0); cycle(); end
    check("p4_route", out_port_o, P_RIGHT);
    drive(0, '0, 0, 1, 2'd1); cycle();
    for (int i = 0; i < 4; i++) begin
      check("p4_order", data_o, {pk[i][W-1:W-2], 2'd1, pk[i][DW-1:0]});
      drive(0, '0, 1, 0, '0); cycle();
    end
    check("p4_swreq_drop", switch_request_o, 0);

    // Fill, overflow, write+read while full
    for (int i = 0; i < BS; i++) begin
      drive(1, mk_flit(i == 0 ? L_HEAD : (i == BS - 1 ? L_TAIL : L_BODY), 1, 1), 0, 0, '0);
      cycle();
    end
    check("fill_full", is_full_o, 1);
    drive(1, mk_flit(L_HT, 4, 4), 0, 0, '0); cycle();
    check("ovf_err", error_o, 1);
    check("ovf_full", is_full_o, 1);
    drive(0, '0, 0, 1, 2'd2); cycle();
    check("ovf_err_once", error_o, 0);
    drive(1, mk_flit(L_HT, 2, 3), 1, 0, '0); cycle();
    check("wr_rd_full", is_full_o, 1);
    check("wr_rd_noerr", error_o, 0);
    drain();

    // Stray BODY at front in IDLE
    drive(1, mk_flit(L_BODY, 0, 0), 0, 0, '0); cycle();
    idle_in(); cycle();
    check("stray_err", error_o, 1);
    check("stray_empty", is_empty_o, 1);

    // read_i during VA, then reset in SA
    drive(1, mk_flit(L_HEAD, 0, 0), 0, 0, '0); cycle();
    idle_in(); cycle();
    drive(0, '0, 1, 0, '0); cycle();
    check("va_read_err", error_o, 1);
    check("va_read_nopop", is_empty_o, 0);
    drive(1, mk_flit(L_BODY, 0, 0), 0, 1, 2'd2); cycle();
    check("sa_reached", switch_request_o, 1);
    idle_in();
    rst = 1'b0;
    #1;
    check("rst_empty", is_empty_o, 1);
    check("rst_req", vc_request_o | switch_request_o, 0);
    check("rst_err", error_o, 0);
    check("rst_route", out_port_o, P_CENTER);
    cycle();
    rst = 1'b1;
    gen_left = 0;

    // Pointer wrap: 5 packets of 4 with interleaved reads, no errors allowed
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, mk_flit(i == 0 ? L_HEAD : (i == 3 ? L_TAIL : L_BODY), p % 5, 1), 0, 0, '0);
        if (m_phase == PH_FORWARD && mq.size() > 0) read_i = 1'b1;
        if (m_phase == PH_WAIT_VC) begin va_done_i = 1'b1; vc_new_i = VCW'(p); end
        cycle();
        check("wrap_noerr", error_o, 0);
      end
    end
    drain();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bit v;
      v = (mq.size() < BS) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      drive(v, v ? gen_flit() : '0,
            (m_phase == PH_FORWARD) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0),
            (m_phase == PH_WAIT_VC) ? $urandom_range(0, 1) : ($urandom_range(0, 19) == 0),
            VCW'($urandom));
      if ($urandom_range(0, 9) == 0) out_port_i = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin rst = 1'b0; gen_left = 0; end
      cycle();
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
